// File: rtl/vending_pkg.sv
// Shared types and helpers for the parametrised vending controller.
package vending_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_VEND,
      ST_CHG_HI,
      ST_CHG_LO
   } state_t;

   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN0     = 2'b01;
   localparam logic [1:0] COIN1     = 2'b10;
   localparam logic [1:0] COIN_BOTH = 2'b11;

   // Credit units contributed by one strobe cycle; both coins may arrive together.
   function automatic int unsigned coin_sum(input logic [1:0] coin,
                                            input int unsigned v0,
                                            input int unsigned v1);
      int unsigned s;
      s = 0;
      if (coin[0]) s = s + v0;
      if (coin[1]) s = s + v1;
      return s;
   endfunction

endpackage

// File: rtl/vending_change_gen.sv
// Change hopper sequencer: loadable down-counter that emits one D_C pulse per unit,
// each high cycle followed by a low cycle.
module vending_change_gen #(
   parameter int unsigned CW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   output logic          D_C,
   output logic [CW-1:0] remaining,
   output logic          done
);

   // A load always starts in the low phase, so the first pulse trails the load by two cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         remaining <= '0;
         D_C       <= 1'b0;
      end else if (load) begin
         remaining <= load_val;
         D_C       <= 1'b0;
      end else if (D_C) begin
         remaining <= remaining - CW'(1);
         D_C       <= 1'b0;
      end else if (remaining != '0) begin
         D_C       <= 1'b1;
      end
   end

   assign done = (remaining == '0) && !D_C;

endmodule

// File: rtl/vending_ctrl_param.sv
// Parametrised vending controller: credit accumulation, dispense, change return,
// cancel/refund and coin rejection while busy. All outputs registered.
module vending_ctrl_param
   import vending_pkg::*;
#(
   parameter  int unsigned PRICE     = 3,
   parameter  int unsigned COIN0_VAL = 1,
   parameter  int unsigned COIN1_VAL = 2,
   localparam int unsigned CW        = $clog2(PRICE + COIN0_VAL + COIN1_VAL)
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic [1:0]    D_in,
   input  logic          Cancel,
   output logic          D_out,
   output logic          D_C,
   output logic [CW-1:0] Credit,
   output logic          Busy,
   output logic          Coin_rej
);

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] credit;
   logic [CW-1:0] credit_nxt;
   logic [CW-1:0] credit_out_nxt;
   logic [CW-1:0] sum_cw;
   logic [CW-1:0] nxt;
   logic          load;
   logic [CW-1:0] load_val;
   logic [CW-1:0] remaining;
   logic          gen_done;

   vending_change_gen #(
      .CW (CW)
   ) u_change_gen (
      .clk       (Clk),
      .rst_n     (Reset),
      .load      (load),
      .load_val  (load_val),
      .D_C       (D_C),
      .remaining (remaining),
      .done      (gen_done)
   );

   // The change generator is loaded on leaving IDLE so it runs in lock-step with the FSM;
   // a cancel enters the low phase directly, mirroring the VEND cycle of a sale.
   always_comb begin
      sum_cw         = CW'(coin_sum(D_in, COIN0_VAL, COIN1_VAL));
      nxt            = credit + sum_cw;
      state_nxt      = state;
      credit_nxt     = credit;
      credit_out_nxt = credit;
      load           = 1'b0;
      load_val       = '0;
      case (state)
         ST_IDLE: begin
            if (nxt >= CW'(PRICE)) begin
               state_nxt      = ST_VEND;
               load           = 1'b1;
               load_val       = nxt - CW'(PRICE);
               credit_nxt     = '0;
               credit_out_nxt = '0;
            end else if (Cancel && (nxt != '0)) begin
               state_nxt      = ST_CHG_LO;
               load           = 1'b1;
               load_val       = nxt;
               credit_nxt     = '0;
               credit_out_nxt = nxt;
            end else begin
               credit_nxt     = nxt;
               credit_out_nxt = nxt;
            end
         end
         ST_VEND, ST_CHG_LO: begin
            if (gen_done) begin
               state_nxt = ST_IDLE;
            end else begin
               state_nxt      = ST_CHG_HI;
               credit_out_nxt = remaining;
            end
         end
         ST_CHG_HI: begin
            state_nxt      = ST_CHG_LO;
            credit_out_nxt = remaining - CW'(1);
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state    <= ST_IDLE;
         credit   <= '0;
         D_out    <= 1'b0;
         Busy     <= 1'b0;
         Coin_rej <= 1'b0;
         Credit   <= '0;
      end else begin
         state    <= state_nxt;
         credit   <= credit_nxt;
         D_out    <= (state_nxt == ST_VEND);
         Busy     <= (state_nxt != ST_IDLE);
         Coin_rej <= (state != ST_IDLE) && (D_in != COIN_NONE);
         Credit   <= credit_out_nxt;
      end
   end

endmodule

// File: tb/tb_vending_ctrl_param.sv
// Directed bench for vending_ctrl_param (PRICE=3, COIN0=1, COIN1=2) with a
// transaction-level reference model checked every cycle.
module tb_vending_ctrl_param;

   localparam int P  = 3;
   localparam int V0 = 1;
   localparam int V1 = 2;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic [1:0] D_in = 2'b00;
   logic       Cancel = 1'b0;
   logic       D_out;
   logic       D_C;
   logic [2:0] Credit;
   logic       Busy;
   logic       Coin_rej;

   int checks = 0;
   int failures = 0;
   int n_dout = 0;
   int n_dc = 0;
   int n_rej = 0;

   vending_ctrl_param #(
      .PRICE     (P),
      .COIN0_VAL (V0),
      .COIN1_VAL (V1)
   ) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .D_in     (D_in),
      .Cancel   (Cancel),
      .D_out    (D_out),
      .D_C      (D_C),
      .Credit   (Credit),
      .Busy     (Busy),
      .Coin_rej (Coin_rej)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: a transaction started in cycle s with k change units is busy for
   // cycles s+1..s+2k+1, dispenses at s+1 (sale only) and pays at s+2,s+4,..,s+2k.
   int cyc, m_s, m_k, m_credit;
   bit m_vend, m_active, m_rej;

   function automatic bit m_busy(input int c);
      int d;
      d = c - m_s;
      return m_active && (d >= 1) && (d <= 2 * m_k + 1);
   endfunction

   always @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         cyc = 0; m_active = 0; m_credit = 0; m_rej = 0; m_s = 0; m_k = 0; m_vend = 0;
      end else begin
         int sum, nx;
         sum = (D_in[0] ? V0 : 0) + (D_in[1] ? V1 : 0);
         if (m_busy(cyc)) begin
            m_rej = (D_in != 2'b00);
         end else begin
            m_rej = 0;
            nx = m_credit + sum;
            if (nx >= P) begin
               m_active = 1; m_s = cyc; m_k = nx - P; m_vend = 1; m_credit = 0;
            end else if (Cancel && nx > 0) begin
               m_active = 1; m_s = cyc; m_k = nx; m_vend = 0; m_credit = 0;
            end else begin
               m_credit = nx;
            end
         end
         cyc++;
      end
   end

   always @(posedge Clk) begin
      int d, e_credit;
      bit b;
      #1;
      d = cyc - m_s;
      b = m_busy(cyc);
      if (!b) e_credit = m_credit;
      else if (m_vend && d == 1) e_credit = 0;
      else e_credit = m_k - (d - 1) / 2;
      chk("D_out", int'(D_out), int'(b && m_vend && d == 1));
      chk("D_C", int'(D_C), int'(b && d >= 2 && (d % 2) == 0));
      chk("Busy", int'(Busy), int'(b));
      chk("Coin_rej", int'(Coin_rej), int'(m_rej));
      chk("Credit", int'(Credit), e_credit);
      if (D_out) n_dout++;
      if (D_C) n_dc++;
      if (Coin_rej) n_rej++;
   end

   task automatic coin(input logic [1:0] c);
      @(negedge Clk) D_in = c;
      @(negedge Clk) D_in = 2'b00;
   endtask

   task automatic cancel_pulse();
      @(negedge Clk) Cancel = 1'b1;
      @(negedge Clk) Cancel = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge Clk);
   endtask

   int d0, c0, r0;

   initial begin
      #2 Reset = 1'b0;
      idle(3);
      chk("reset_busy", int'(Busy), 0);
      chk("reset_credit", int'(Credit), 0);
      Reset = 1'b1;
      idle(2);

      // 1: three single-unit coins
      coin(2'b01); chk("t1_credit1", int'(Credit), 1);
      idle(2);
      coin(2'b01); chk("t1_credit2", int'(Credit), 2);
      idle(2);
      d0 = n_dout; c0 = n_dc;
      coin(2'b01); chk("t1_dout_now", int'(D_out), 1);
      idle(6);
      chk("t1_dout_cnt", n_dout - d0, 1);
      chk("t1_dc_cnt", n_dc - c0, 0);

      // 2: 2+2 -> one change unit
      d0 = n_dout; c0 = n_dc;
      coin(2'b10); coin(2'b10);
      idle(8);
      chk("t2_dout_cnt", n_dout - d0, 1);
      chk("t2_dc_cnt", n_dc - c0, 1);
      chk("t2_credit", int'(Credit), 0);

      // 3: 2 then both -> five units, two change pulses
      d0 = n_dout; c0 = n_dc;
      coin(2'b10); coin(2'b11);
      idle(10);
      chk("t3_dout_cnt", n_dout - d0, 1);
      chk("t3_dc_cnt", n_dc - c0, 2);
      chk("t3_busy", int'(Busy), 0);

      // 4: refund, then cancel with nothing inserted
      d0 = n_dout; c0 = n_dc;
      coin(2'b01); idle(2); cancel_pulse();
      idle(8);
      chk("t4_dc_cnt", n_dc - c0, 1);
      chk("t4_dout_cnt", n_dout - d0, 0);
      chk("t4_credit", int'(Credit), 0);
      c0 = n_dc;
      cancel_pulse();
      chk("t4_idle_busy", int'(Busy), 0);
      idle(4);
      chk("t4_idle_dc", n_dc - c0, 0);

      // 5: coins while VEND and while CHANGE are rejected
      c0 = n_dc; r0 = n_rej;
      @(negedge Clk) D_in = 2'b10;
      @(negedge Clk) D_in = 2'b10;
      @(negedge Clk) D_in = 2'b01;
      @(negedge Clk) D_in = 2'b00;
      @(negedge Clk) D_in = 2'b01;
      @(negedge Clk) D_in = 2'b00;
      idle(8);
      chk("t5_rej_cnt", n_rej - r0, 2);
      chk("t5_dc_cnt", n_dc - c0, 1);
      chk("t5_credit", int'(Credit), 0);

      // 6: reset after the first change pulse abandons the rest
      c0 = n_dc;
      @(negedge Clk) D_in = 2'b10;
      @(negedge Clk) D_in = 2'b11;
      @(negedge Clk) D_in = 2'b00;
      @(negedge Clk);
      @(negedge Clk);
      chk("t6_dc_before", n_dc - c0, 1);
      Reset = 1'b0;
      #1;
      chk("t6_rst_dc", int'(D_C), 0);
      chk("t6_rst_busy", int'(Busy), 0);
      chk("t6_rst_credit", int'(Credit), 0);
      chk("t6_rst_dout", int'(D_out), 0);
      idle(2);
      Reset = 1'b1;
      idle(8);
      chk("t6_dc_after", n_dc - c0, 1);
      chk("t6_busy", int'(Busy), 0);

      // exact-price sale after reset: no change
      d0 = n_dout; c0 = n_dc;
      coin(2'b10); coin(2'b01);
      idle(6);
      chk("t7_dout_cnt", n_dout - d0, 1);
      chk("t7_dc_cnt", n_dc - c0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
